mbldcm_avmm_csr_multi: RTL and testbench
========================================

# mbldcm_avmm_csr_multi

Multi-channel Avalon-MM control/status register bank for the mBldcm motor subsystem. One slave port serves `pNumCh` independent BLDC channels and one global page. Per channel it provides the frequency target, phase update, control and status registers. It adds registered read responses, write responses, registered latch strobes, sticky write-1-to-clear event flags and a level interrupt. It sits between the Avalon-MM interconnect and the per-channel frequency/phase/drive cores.

## Interface
Parameters:
- `pNumCh`, 4: channel count, legal 1..7.
- `pFreqWidth`, 32: frequency target width, legal 1..32.
- `pPhaseWidth`, 4: phase word width, legal 1..8.

Ports:
- `iClock`  in  1  sole clock; all logic on the rising edge.
- `iReset_n`  in  1  asynchronous, active-low reset.
- `iAddr`  in  5  word address: bits [4:2] select the page (0..pNumCh-1 = channel, 7 = global); bits [1:0] select the register.
- `iRead`, `iWrite`  in  1 each  access strobes.
- `iWdata`  in  32  write data.
- `oRdata`  out  32  read data.
- `oRdataValid`  out  1  read response strobe.
- `oWriteRespValid`  out  1  write response strobe.
- `oResp`  out  2  response code: 00 OKAY, 10 SLAVEERROR, 11 DECODEERROR.
- `oFreqTarget`  out  pNumCh*pFreqWidth  per-channel target; channel n occupies slice n.
- `oLatchFreqTarget`  out  pNumCh  one-cycle strobe per channel.
- `iFreqTarget`  in  pNumCh*pFreqWidth  current target read back from each core.
- `oPhaseUpdate`  out  pNumCh*pPhaseWidth  phase write data.
- `oLatchPhaseUpdate`  out  pNumCh  one-cycle strobe per channel.
- `iPhase`  in  pNumCh*pPhaseWidth  current phase.
- `oEnable`  out  pNumCh  drive enable per channel.
- `iFreqReflected`, `iStop`  in  pNumCh each  live status.
- `oIrq`  out  1  level interrupt.

## Operation
- Channel page registers:
  - Reg 0 FREQ: read returns `iFreqTarget[n]`, zero-extended. Write loads `iWdata[pFreqWidth-1:0]` into `oFreqTarget[n]` and pulses `oLatchFreqTarget[n]`.
  - Reg 1 PHASE: read returns `iPhase[n]`, zero-extended. Write loads `oPhaseUpdate[n]` and pulses `oLatchPhaseUpdate[n]`.
  - Reg 2 CTRL: R/W. Bit 0 = enable, drives `oEnable[n]`. Bit 1 = stop-event IRQ enable. Bit 2 = reflect-event IRQ enable. Other bits are written-ignored and read as 0.
  - Reg 3 STAT:
    - Bit 0 = `iStop` live. Bit 1 = `iFreqReflected` live.
    - Bit 2 = STOP_EV, sticky, set on a rising edge of `iStop`.
    - Bit 3 = REFL_EV, sticky, set on a rising edge of `iFreqReflected`.
    - Writing 1 to bit 2 or 3 clears that bit. Writes to other bits are ignored. Response is OKAY.
- Global page (page 7):
  - Reg 0 IRQ_PEND: read-only. Bit n = (STOP_EV & CTRL[1]) | (REFL_EV & CTRL[2]) for channel n.
  - Reg 1 ID: read-only, returns {8'hB1, 8'h02, 8'(pNumCh), 8'(pFreqWidth)}.
  - Reg 2 EN_ALL: read returns `oEnable`, zero-extended. Write sets CTRL[0] of every channel n from `iWdata[n]`; other CTRL bits are untouched.
  - Reg 3: decode error.
- Errors:
  - A page in pNumCh..6, or global reg 3: read returns 32'hFFFFFFFF with DECODEERROR; write has no effect and returns DECODEERROR.
  - Write to IRQ_PEND or ID: no effect, SLAVEERROR.
- `iRead` and `iWrite` asserted together: the write executes and the read is dropped (no `oRdataValid`).
- Edge detectors: previous-value registers reset to 1, so an input already high at reset release raises no event.
- Event set and W1C clear in the same cycle: set wins and the bit stays 1.
- `oIrq` = registered OR of IRQ_PEND.

## Timing
- Every access is accepted in one cycle, with no wait states. Back-to-back accesses on consecutive cycles are legal.
- Read response: access on edge k produces `oRdata`, `oResp` and `oRdataValid`=1 valid for the cycle after edge k. Data is sampled at edge k; STAT returns its pre-edge-k value. `oRdata` = 0 when not valid.
- Write response: `oWriteRespValid`=1 and `oResp` in the cycle after edge k. `oResp` = 00 when neither response strobe is valid.
- Write at edge k:
  - Register contents update at edge k.
  - `oFreqTarget` / `oPhaseUpdate` and their strobes change at edge k. Each strobe is high exactly one cycle, aligned with the new data.
- Input edge sampled at edge k: the sticky bit is 1 after edge k, and `oIrq` is 1 after edge k+1. Clearing the cause drops `oIrq` one edge later.
- Reset values: all outputs 0 (`oRdata`, `oResp`, both valids, `oFreqTarget`, `oPhaseUpdate`, both strobe buses, `oEnable`, `oIrq`). CTRL and STAT sticky bits are 0.
- Reset asserted mid-operation: all outputs clear immediately (asynchronous), and any pending response is discarded.

## Test plan
- Reset release with `iStop`=1 on channel 0, then read STAT (addr 0x03) -> `oRdataValid` the next cycle, data 0x1, OKAY, `oIrq`=0.
- Write 0x12345678 to channel 2 FREQ (addr 0x08), pNumCh=4 -> `oFreqTarget` slice 2 = 0x12345678 and `oLatchFreqTarget`=4'b0100 for exactly one cycle after the write edge; `oWriteRespValid` with OKAY.
- Channel 1 CTRL=0x3, then pulse `iStop[1]` -> STAT bit 2 set, IRQ_PEND (addr 0x1C) reads 0x2, `oIrq`=1.
  - Write 0x4 to addr 0x07 -> `oIrq` drops.
  - Repeat with a new edge in the same cycle as the W1C write -> the bit stays set.
- Write 0x5 to EN_ALL (addr 0x1E) -> `oEnable`=4'b0101; CTRL[1:2] of each channel unchanged.
- Read addr 0x10 (page 4, pNumCh=4) -> 32'hFFFFFFFF with DECODEERROR. Write to ID (addr 0x1D) -> SLAVEERROR and no state change.
- Simultaneous read+write to addr 0x02 -> CTRL updated, no `oRdataValid`. Assert `iReset_n`=0 mid-pulse of a latch strobe -> all outputs 0 immediately.

Source files
------------

// File: rtl/mbldcm_avmm_csr_multi.sv
// Avalon-MM CSR bank for the mBldcm motor subsystem: per-channel FREQ/PHASE/CTRL/STAT pages
// plus a global page (IRQ summary, ID, enable-all), zero-wait-state accept, registered responses.
module mbldcm_avmm_csr_multi #(
    parameter int pNumCh      = 4,
    parameter int pFreqWidth  = 32,
    parameter int pPhaseWidth = 4
) (
    input  logic                          iClock,
    input  logic                          iReset_n,
    input  logic [4:0]                    iAddr,
    input  logic                          iRead,
    input  logic                          iWrite,
    input  logic [31:0]                   iWdata,
    output logic [31:0]                   oRdata,
    output logic                          oRdataValid,
    output logic                          oWriteRespValid,
    output logic [1:0]                    oResp,
    output logic [pNumCh*pFreqWidth-1:0]  oFreqTarget,
    output logic [pNumCh-1:0]             oLatchFreqTarget,
    input  logic [pNumCh*pFreqWidth-1:0]  iFreqTarget,
    output logic [pNumCh*pPhaseWidth-1:0] oPhaseUpdate,
    output logic [pNumCh-1:0]             oLatchPhaseUpdate,
    input  logic [pNumCh*pPhaseWidth-1:0] iPhase,
    output logic [pNumCh-1:0]             oEnable,
    input  logic [pNumCh-1:0]             iFreqReflected,
    input  logic [pNumCh-1:0]             iStop,
    output logic                          oIrq
);

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } tResp;

    localparam logic [2:0]  cGlobalPage = 3'd7;
    localparam logic [31:0] cIdWord     = {8'hB1, 8'h02, 8'(pNumCh), 8'(pFreqWidth)};

    logic [2:0]        page;
    logic [1:0]        regSel;
    logic [pNumCh-1:0] chHit;
    logic              isGlobal;
    logic              decodeErr;
    logic              readOnlyErr;
    logic              doRead;
    tResp              accessResp;
    logic [31:0]       readMux;

    logic [pNumCh-1:0] wrChan;
    logic [pNumCh-1:0] wrFreq;
    logic [pNumCh-1:0] wrPhase;
    logic [pNumCh-1:0] wrCtrl;
    logic [pNumCh-1:0] wrStat;
    logic              wrEnAll;

    logic [pNumCh-1:0] ctrlStopIe;
    logic [pNumCh-1:0] ctrlReflIe;
    logic [pNumCh-1:0] stopEv;
    logic [pNumCh-1:0] reflEv;
    logic [pNumCh-1:0] stopPrev;
    logic [pNumCh-1:0] reflPrev;
    logic [pNumCh-1:0] stopRise;
    logic [pNumCh-1:0] reflRise;
    logic [pNumCh-1:0] stopClr;
    logic [pNumCh-1:0] reflClr;
    logic [pNumCh-1:0] irqPend;

    // ---------------- address decode ----------------
    assign page   = iAddr[4:2];
    assign regSel = iAddr[1:0];

    always_comb begin
        for (int n = 0; n < pNumCh; n++) begin
            chHit[n] = (page == 3'(n));
        end
    end

    assign isGlobal    = (page == cGlobalPage);
    assign decodeErr   = ~(|chHit) & ~(isGlobal & (regSel != 2'd3));
    assign readOnlyErr = isGlobal & (regSel <= 2'd1);
    // A simultaneous read and write is treated as a write; the read is dropped.
    assign doRead      = iRead & ~iWrite;

    // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
    always_comb begin
        accessResp = RESP_OKAY;
        if (decodeErr) begin
            accessResp = RESP_DECERR;
        end else if (iWrite && readOnlyErr) begin
            accessResp = RESP_SLVERR;
        end
    end

    always_comb begin
        readMux = 32'hFFFF_FFFF;
        if (isGlobal) begin
            case (regSel)
                2'd0:    readMux = 32'(irqPend);
                2'd1:    readMux = cIdWord;
                2'd2:    readMux = 32'(oEnable);
                default: readMux = 32'hFFFF_FFFF;
            endcase
        end
        for (int n = 0; n < pNumCh; n++) begin
            if (chHit[n]) begin
                case (regSel)
                    2'd0:    readMux = 32'(iFreqTarget[n*pFreqWidth +: pFreqWidth]);
                    2'd1:    readMux = 32'(iPhase[n*pPhaseWidth +: pPhaseWidth]);
                    2'd2:    readMux = {29'd0, ctrlReflIe[n], ctrlStopIe[n], oEnable[n]};
                    default: readMux = {28'd0, reflEv[n], stopEv[n], iFreqReflected[n], iStop[n]};
                endcase
            end
        end
    end

    // ---------------- write strobes ----------------
    assign wrChan  = {pNumCh{iWrite}} & chHit;
    assign wrFreq  = wrChan & {pNumCh{regSel == 2'd0}};
    assign wrPhase = wrChan & {pNumCh{regSel == 2'd1}};
    assign wrCtrl  = wrChan & {pNumCh{regSel == 2'd2}};
    assign wrStat  = wrChan & {pNumCh{regSel == 2'd3}};
    assign wrEnAll = iWrite & isGlobal & (regSel == 2'd2);

    // ---------------- sticky events ----------------
    assign stopRise = iStop & ~stopPrev;
    assign reflRise = iFreqReflected & ~reflPrev;
    assign stopClr  = wrStat & {pNumCh{iWdata[2]}};
    assign reflClr  = wrStat & {pNumCh{iWdata[3]}};
    assign irqPend  = (stopEv & ctrlStopIe) | (reflEv & ctrlReflIe);

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            // Previous values reset high so an input already asserted at release is not an edge.
            stopPrev <= '1;
            reflPrev <= '1;
            stopEv   <= '0;
            reflEv   <= '0;
            oIrq     <= 1'b0;
        end else begin
            stopPrev <= iStop;
            reflPrev <= iFreqReflected;
            // Set is OR-ed in after the clear so a same-cycle edge wins over W1C.
            stopEv   <= (stopEv & ~stopClr) | stopRise;
            reflEv   <= (reflEv & ~reflClr) | reflRise;
            oIrq     <= |irqPend;
        end
    end

    // ---------------- per-channel control and data ----------------
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            oFreqTarget       <= '0;
            oPhaseUpdate      <= '0;
            oLatchFreqTarget  <= '0;
            oLatchPhaseUpdate <= '0;
            oEnable           <= '0;
            ctrlStopIe        <= '0;
            ctrlReflIe        <= '0;
        end else begin
            oLatchFreqTarget  <= wrFreq;
            oLatchPhaseUpdate <= wrPhase;
            for (int n = 0; n < pNumCh; n++) begin
                if (wrFreq[n]) begin
                    oFreqTarget[n*pFreqWidth +: pFreqWidth] <= iWdata[pFreqWidth-1:0];
                end
                if (wrPhase[n]) begin
                    oPhaseUpdate[n*pPhaseWidth +: pPhaseWidth] <= iWdata[pPhaseWidth-1:0];
                end
                if (wrCtrl[n]) begin
                    oEnable[n]    <= iWdata[0];
                    ctrlStopIe[n] <= iWdata[1];
                    ctrlReflIe[n] <= iWdata[2];
                end else if (wrEnAll) begin
                    oEnable[n] <= iWdata[n];
                end
            end
        end
    end

    // ---------------- bus responses ----------------
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            oRdata          <= '0;
            oRdataValid     <= 1'b0;
            oWriteRespValid <= 1'b0;
            oResp           <= RESP_OKAY;
        end else begin
            oRdata          <= doRead ? readMux : 32'd0;
            oRdataValid     <= doRead;
            oWriteRespValid <= iWrite;
            oResp           <= (iRead | iWrite) ? accessResp : RESP_OKAY;
        end
    end

endmodule

// File: tb/tb_mbldcm_avmm_csr_multi.sv
// Self-checking bench for mbldcm_avmm_csr_multi: directed accesses, a behavioural register model
// compared on every falling edge, and literal expectations at the key points.
module tb_mbldcm_avmm_csr_multi;

    localparam int NCH = 4;
    localparam int FW  = 32;
    localparam int PW  = 4;

    logic              iClock   = 1'b0;
    logic              iReset_n = 1'b1;
    logic [4:0]        iAddr    = '0;
    logic              iRead    = 1'b0;
    logic              iWrite   = 1'b0;
    logic [31:0]       iWdata   = '0;
    logic [31:0]       oRdata;
    logic              oRdataValid;
    logic              oWriteRespValid;
    logic [1:0]        oResp;
    logic [NCH*FW-1:0] oFreqTarget;
    logic [NCH-1:0]    oLatchFreqTarget;
    logic [NCH*FW-1:0] iFreqTarget;
    logic [NCH*PW-1:0] oPhaseUpdate;
    logic [NCH-1:0]    oLatchPhaseUpdate;
    logic [NCH*PW-1:0] iPhase;
    logic [NCH-1:0]    oEnable;
    logic [NCH-1:0]    iFreqReflected = '0;
    logic [NCH-1:0]    iStop          = '0;
    logic              oIrq;

    int nChecks = 0;
    int nBad    = 0;
    bit cmpEn   = 1'b0;

    mbldcm_avmm_csr_multi #(
        .pNumCh      (NCH),
        .pFreqWidth  (FW),
        .pPhaseWidth (PW)
    ) dut (
        .iClock            (iClock),
        .iReset_n          (iReset_n),
        .iAddr             (iAddr),
        .iRead             (iRead),
        .iWrite            (iWrite),
        .iWdata            (iWdata),
        .oRdata            (oRdata),
        .oRdataValid       (oRdataValid),
        .oWriteRespValid   (oWriteRespValid),
        .oResp             (oResp),
        .oFreqTarget       (oFreqTarget),
        .oLatchFreqTarget  (oLatchFreqTarget),
        .iFreqTarget       (iFreqTarget),
        .oPhaseUpdate      (oPhaseUpdate),
        .oLatchPhaseUpdate (oLatchPhaseUpdate),
        .iPhase            (iPhase),
        .oEnable           (oEnable),
        .iFreqReflected    (iFreqReflected),
        .iStop             (iStop),
        .oIrq              (oIrq)
    );

    always #5 iClock = ~iClock;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0]   mFreq  [NCH];
    logic [PW-1:0] mPhase [NCH];
    bit            mEn [NCH], mSie [NCH], mRie [NCH];
    bit            mSev [NCH], mRev [NCH], mPrevStop [NCH], mPrevRefl [NCH];

    logic [31:0]    eRdata;
    bit             eRvalid, eWvalid, eIrq;
    logic [1:0]     eResp;
    logic [NCH-1:0] eLatchF, eLatchP;

    int          pg, rg, pendMask, enMask;
    logic [31:0] rv;
    logic [1:0]  rs;

    always @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            for (int n = 0; n < NCH; n++) begin
                mFreq[n] = '0; mPhase[n] = '0;
                mEn[n] = 0; mSie[n] = 0; mRie[n] = 0; mSev[n] = 0; mRev[n] = 0;
                mPrevStop[n] = 1; mPrevRefl[n] = 1;
            end
            eRdata = '0; eRvalid = 0; eWvalid = 0; eResp = '0;
            eLatchF = '0; eLatchP = '0; eIrq = 0;
        end else begin
            pendMask = 0;
            enMask   = 0;
            for (int n = 0; n < NCH; n++) begin
                if ((mSev[n] && mSie[n]) || (mRev[n] && mRie[n])) pendMask += (1 << n);
                if (mEn[n]) enMask += (1 << n);
            end
            eIrq    = (pendMask != 0);
            eRdata  = '0; eRvalid = 0; eWvalid = 0; eResp = '0;
            eLatchF = '0; eLatchP = '0;

            pg = int'(iAddr) / 4;
            rg = int'(iAddr) % 4;
            rv = 32'hFFFF_FFFF;
            rs = 2'b11;
            if (pg < NCH) begin
                rs = 2'b00;
                case (rg)
                    0: rv = iFreqTarget[pg*FW +: FW];
                    1: rv = 32'(iPhase[pg*PW +: PW]);
                    2: rv = 32'(int'(mEn[pg]) + 2*int'(mSie[pg]) + 4*int'(mRie[pg]));
                    default: rv = 32'(int'(iStop[pg]) + 2*int'(iFreqReflected[pg])
                                      + 4*int'(mSev[pg]) + 8*int'(mRev[pg]));
                endcase
            end else if (pg == 7 && rg != 3) begin
                rs = (iWrite && rg < 2) ? 2'b10 : 2'b00;
                case (rg)
                    0:       rv = 32'(pendMask);
                    1:       rv = 32'hB102_0420;
                    default: rv = 32'(enMask);
                endcase
            end

            if (iWrite) begin
                eWvalid = 1;
                eResp   = rs;
                if (pg < NCH) begin
                    case (rg)
                        0: begin mFreq[pg] = iWdata; eLatchF[pg] = 1'b1; end
                        1: begin mPhase[pg] = iWdata[PW-1:0]; eLatchP[pg] = 1'b1; end
                        2: begin mEn[pg] = iWdata[0]; mSie[pg] = iWdata[1]; mRie[pg] = iWdata[2]; end
                        default: begin
                            if (iWdata[2]) mSev[pg] = 0;
                            if (iWdata[3]) mRev[pg] = 0;
                        end
                    endcase
                end else if (pg == 7 && rg == 2) begin
                    for (int n = 0; n < NCH; n++) mEn[n] = iWdata[n];
                end
            end else if (iRead) begin
                eRvalid = 1;
                eRdata  = rv;
                eResp   = rs;
            end

            for (int n = 0; n < NCH; n++) begin
                if (iStop[n] && !mPrevStop[n]) mSev[n] = 1;
                if (iFreqReflected[n] && !mPrevRefl[n]) mRev[n] = 1;
                mPrevStop[n] = iStop[n];
                mPrevRefl[n] = iFreqReflected[n];
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [NCH*FW-1:0] xFreq;
    logic [NCH*PW-1:0] xPhase;
    logic [NCH-1:0]    xEn;

    always @(negedge iClock) begin
        if (cmpEn) begin
            for (int n = 0; n < NCH; n++) begin
                xFreq[n*FW +: FW]  = mFreq[n];
                xPhase[n*PW +: PW] = mPhase[n];
                xEn[n]             = mEn[n];
            end
            check("cyc_rdata",   128'(oRdata),            128'(eRdata));
            check("cyc_rvalid",  128'(oRdataValid),       128'(eRvalid));
            check("cyc_wvalid",  128'(oWriteRespValid),   128'(eWvalid));
            check("cyc_resp",    128'(oResp),             128'(eResp));
            check("cyc_freq",    128'(oFreqTarget),       128'(xFreq));
            check("cyc_latchf",  128'(oLatchFreqTarget),  128'(eLatchF));
            check("cyc_phase",   128'(oPhaseUpdate),      128'(xPhase));
            check("cyc_latchp",  128'(oLatchPhaseUpdate), 128'(eLatchP));
            check("cyc_enable",  128'(oEnable),           128'(xEn));
            check("cyc_irq",     128'(oIrq),              128'(eIrq));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge iClock);
        iAddr = a; iWdata = d; iWrite = 1'b1; iRead = 1'b0;
        @(negedge iClock);
        iWrite = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        @(negedge iClock);
        iAddr = a; iRead = 1'b1; iWrite = 1'b0;
        @(negedge iClock);
        iRead = 1'b0;
    endtask

    task automatic pulseStop(input int n);
        @(negedge iClock); iStop[n] = 1'b1;
        @(negedge iClock); iStop[n] = 1'b0;
    endtask

    task automatic pulseRefl(input int n);
        @(negedge iClock); iFreqReflected[n] = 1'b1;
        @(negedge iClock); iFreqReflected[n] = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_rdata"},  128'(oRdata),            128'(0));
        check({tag, "_rvalid"}, 128'(oRdataValid),       128'(0));
        check({tag, "_wvalid"}, 128'(oWriteRespValid),   128'(0));
        check({tag, "_resp"},   128'(oResp),             128'(0));
        check({tag, "_freq"},   128'(oFreqTarget),       128'(0));
        check({tag, "_latchf"}, 128'(oLatchFreqTarget),  128'(0));
        check({tag, "_phase"},  128'(oPhaseUpdate),      128'(0));
        check({tag, "_latchp"}, 128'(oLatchPhaseUpdate), 128'(0));
        check({tag, "_enable"}, 128'(oEnable),           128'(0));
        check({tag, "_irq"},    128'(oIrq),              128'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        for (int n = 0; n < NCH; n++) begin
            iFreqTarget[n*FW +: FW] = 32'hF000_0000 | 32'(n * 32'h111);
            iPhase[n*PW +: PW]      = 4'(n + 5);
        end
        iStop = 4'b0001;
        #1 iReset_n = 1'b0;
        cmpEn = 1'b1;
        repeat (3) @(negedge iClock);
        checkAllZero("reset");
        iReset_n = 1'b1;

        // STAT of channel 0 with iStop high through reset: live bit only, no event.
        rd(5'h03);
        check("stat0_valid", 128'(oRdataValid), 128'(1));
        check("stat0_data",  128'(oRdata),      128'(32'h1));
        check("stat0_resp",  128'(oResp),       128'(2'b00));
        check("stat0_irq",   128'(oIrq),        128'(0));

        // FREQ write to channel 2.
        wr(5'h08, 32'h1234_5678);
        check("freq2_data",   128'(oFreqTarget[2*FW +: FW]), 128'(32'h1234_5678));
        check("freq2_strobe", 128'(oLatchFreqTarget),        128'(4'b0100));
        check("freq2_wvalid", 128'(oWriteRespValid),         128'(1));
        check("freq2_resp",   128'(oResp),                   128'(2'b00));
        @(negedge iClock);
        check("freq2_strobe_end", 128'(oLatchFreqTarget), 128'(4'b0000));

        // Stop event on channel 1 with its IRQ enabled.
        wr(5'h06, 32'h3);
        pulseStop(1);
        check("irq_lag", 128'(oIrq), 128'(0));
        @(negedge iClock);
        check("irq_set", 128'(oIrq), 128'(1));
        rd(5'h07);
        check("stat1_ev", 128'(oRdata), 128'(32'h4));
        rd(5'h1C);
        check("irq_pend", 128'(oRdata), 128'(32'h2));
        wr(5'h07, 32'h4);
        check("irq_hold", 128'(oIrq), 128'(1));
        @(negedge iClock);
        check("irq_clr", 128'(oIrq), 128'(0));

        // New edge in the same cycle as the W1C write: set wins.
        pulseStop(1);
        @(negedge iClock);
        iStop[1] = 1'b1; iAddr = 5'h07; iWdata = 32'h4; iWrite = 1'b1;
        @(negedge iClock);
        iWrite = 1'b0; iStop[1] = 1'b0;
        rd(5'h07);
        check("w1c_vs_set", 128'(oRdata), 128'(32'h4));
        wr(5'h07, 32'h4);
        repeat (2) @(negedge iClock);
        check("irq_clr2", 128'(oIrq), 128'(0));

        // EN_ALL touches only the enable bit.
        wr(5'h1E, 32'h5);
        check("en_all", 128'(oEnable), 128'(4'b0101));
        rd(5'h06);
        check("ctrl1_keep", 128'(oRdata), 128'(32'h2));
        rd(5'h1E);
        check("en_all_rd", 128'(oRdata), 128'(32'h5));

        // Decode and slave errors.
        rd(5'h10);
        check("dec_rd_data", 128'(oRdata), 128'(32'hFFFF_FFFF));
        check("dec_rd_resp", 128'(oResp),  128'(2'b11));
        rd(5'h1F);
        check("g3_rd_resp", 128'(oResp), 128'(2'b11));
        wr(5'h14, 32'h1);
        check("dec_wr_resp", 128'(oResp), 128'(2'b11));
        wr(5'h1D, 32'h0);
        check("id_wr_resp", 128'(oResp), 128'(2'b10));
        rd(5'h1D);
        check("id_rd", 128'(oRdata), 128'(32'hB102_0420));
        wr(5'h1C, 32'hFFFF_FFFF);
        check("pend_wr_resp", 128'(oResp), 128'(2'b10));
        rd(5'h1C);
        check("pend_rd", 128'(oRdata), 128'(32'h0));

        // Read and write together: write wins, no read response.
        @(negedge iClock);
        iAddr = 5'h02; iWdata = 32'h6; iRead = 1'b1; iWrite = 1'b1;
        @(negedge iClock);
        iRead = 1'b0; iWrite = 1'b0;
        check("rw_rvalid", 128'(oRdataValid),     128'(0));
        check("rw_wvalid", 128'(oWriteRespValid), 128'(1));
        check("rw_enable", 128'(oEnable),         128'(4'b0100));
        rd(5'h02);
        check("rw_ctrl", 128'(oRdata), 128'(32'h6));

        // Phase write and read-back of live inputs.
        wr(5'h05, 32'hA);
        check("phase1_data",   128'(oPhaseUpdate[1*PW +: PW]), 128'(4'hA));
        check("phase1_strobe", 128'(oLatchPhaseUpdate),       128'(4'b0010));
        rd(5'h0C);
        check("freq3_rd", 128'(oRdata), 128'(32'hF000_0333));

        // Reflect event on channel 3; W1C of the stop bit leaves it alone.
        wr(5'h0E, 32'h4);
        pulseRefl(3);
        @(negedge iClock);
        check("refl_irq", 128'(oIrq), 128'(1));
        rd(5'h1C);
        check("refl_pend", 128'(oRdata), 128'(32'h8));
        wr(5'h0F, 32'h4);
        rd(5'h0F);
        check("refl_keep", 128'(oRdata), 128'(32'h8));

        // Back-to-back accesses on consecutive cycles.
        @(negedge iClock);
        iAddr = 5'h09; iWdata = 32'h3; iWrite = 1'b1; iRead = 1'b0;
        @(negedge iClock);
        check("b2b_phase2", 128'(oPhaseUpdate[2*PW +: PW]), 128'(4'h3));
        iAddr = 5'h09; iWrite = 1'b0; iRead = 1'b1;
        @(negedge iClock);
        check("b2b_rd_phase", 128'(oRdata), 128'(32'h7));
        iAddr = 5'h00; iWdata = 32'hDEAD_BEEF; iWrite = 1'b1; iRead = 1'b0;
        @(negedge iClock);
        check("b2b_freq0", 128'(oFreqTarget[0 +: FW]), 128'(32'hDEAD_BEEF));
        iAddr = 5'h1E; iWrite = 1'b0; iRead = 1'b1;
        @(negedge iClock);
        check("b2b_en_rd", 128'(oRdata), 128'(32'h4));
        iAddr = 5'h13; iRead = 1'b1;
        @(negedge iClock);
        check("b2b_dec", 128'(oResp), 128'(2'b11));
        iAddr = 5'h1F; iWrite = 1'b1; iRead = 1'b0;
        @(negedge iClock);
        iWrite = 1'b0;
        check("b2b_dec_wr", 128'(oResp), 128'(2'b11));

        // Asynchronous reset while a latch strobe is high.
        @(negedge iClock);
        iAddr = 5'h00; iWdata = 32'hCAFE_0001; iWrite = 1'b1;
        @(posedge iClock);
        #1;
        check("pre_rst_strobe", 128'(oLatchFreqTarget), 128'(4'b0001));
        iReset_n = 1'b0;
        iWrite   = 1'b0;
        #1;
        checkAllZero("midrst");
        repeat (2) @(negedge iClock);
        iReset_n = 1'b1;
        rd(5'h03);
        check("post_rst_stat", 128'(oRdata), 128'(32'h1));
        rd(5'h02);
        check("post_rst_ctrl", 128'(oRdata), 128'(32'h0));

        @(negedge iClock);
        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
